// File: rtl/nios_cpu_cpu_debug_host_pkg.sv
// Shared types and constants for the host-side virtual-JTAG debug sequencer.
package nios_cpu_cpu_debug_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    DONE
  } state_t;

  // Instruction codes understood by the CPU debug slave
  localparam logic [1:0] IR_OCIMEM     = 2'b00;
  localparam logic [1:0] IR_TRACE      = 2'b01;
  localparam logic [1:0] IR_BREAK      = 2'b10;
  localparam logic [1:0] IR_TRACE_CTRL = 2'b11;

  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;
  localparam int DEF_TCK_DIV  = 2;

endpackage

// File: rtl/nios_cpu_cpu_debug_host_tckgen.sv
// Divides clk down to tck and flags the clk edges on which tck rises or falls.
module nios_cpu_cpu_debug_host_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             term;

  assign term     = en && (div == DIV_W'(TCK_DIV - 1));
  assign tck_rise = term && !tck;
  assign tck_fall = term && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      div <= '0;
      tck <= 1'b0;
    end else if (term) begin
      div <= '0;
      tck <= ~tck;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/nios_cpu_cpu_debug_host_seq.sv
// Host-side sequencer: runs one IR load plus optional DR shift per accepted command.
module nios_cpu_cpu_debug_host_seq
  import nios_cpu_cpu_debug_host_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int TCK_DIV  = DEF_TCK_DIV
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  input  logic                cmd_skip_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                busy,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  state_t              state, state_nxt;
  logic                tck_rise, tck_fall, tck_en;
  logic                skip_dr;
  logic [DR_WIDTH-1:0] shift;
  logic [CNT_W-1:0]    bit_cnt;
  logic                last_bit;

  // tck only runs inside the JTAG phases so DONE cannot leak an extra edge
  assign tck_en   = (state == UIR) || (state == CDR) || (state == SDR) || (state == UDR);
  assign last_bit = (bit_cnt == CNT_W'(DR_WIDTH - 1));

  nios_cpu_cpu_debug_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (tck_en),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    jtag_state_rti = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready      = 1'b1;
        jtag_state_rti = 1'b1;
        if (cmd_valid) state_nxt = UIR;
      end
      UIR: begin
        vs_uir = 1'b1;
        if (tck_fall) state_nxt = skip_dr ? DONE : CDR;
      end
      CDR: begin
        vs_cdr = 1'b1;
        if (tck_fall) state_nxt = SDR;
      end
      SDR: begin
        vs_sdr = 1'b1;
        if (tck_fall && last_bit) state_nxt = UDR;
      end
      UDR: begin
        vs_udr = 1'b1;
        if (tck_fall) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = ~cmd_ready;

  // Capture on tck rise, launch the next tdi bit on tck fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_in    <= '0;
      shift    <= '0;
      skip_dr  <= 1'b0;
      bit_cnt  <= '0;
      tdi      <= 1'b0;
      rsp_data <= '0;
      rsp_ir   <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        ir_in   <= cmd_ir;
        shift   <= cmd_data;
        skip_dr <= cmd_skip_dr;
        bit_cnt <= '0;
        tdi     <= 1'b0;
      end
      if (tck_rise) begin
        if (state == UIR) rsp_ir <= ir_out;
        if (state == SDR) rsp_data[bit_cnt] <= tdo;
      end
      if (tck_fall) begin
        if (state == CDR) tdi <= shift[0];
        if (state == SDR) begin
          if (last_bit) begin
            tdi <= 1'b0;
          end else begin
            tdi     <= shift[1];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nios_cpu_cpu_debug_host_seq.sv
// Directed bench for the debug host sequencer at TCK_DIV=2 and TCK_DIV=1.
module tb_nios_cpu_cpu_debug_host_seq;

  localparam int DW = 38;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_valid1 = 1'b0;
  logic          cmd_skip_dr = 1'b0;
  logic [IW-1:0] cmd_ir = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [IW-1:0] ir_out = '0;

  logic          cmd_ready, rsp_valid, busy, tck, tdi, tdo;
  logic [DW-1:0] rsp_data;
  logic [IW-1:0] rsp_ir, ir_in;
  logic          vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

  logic          cmd_ready1, rsp_valid1, busy1, tck1, tdi1;
  logic [DW-1:0] rsp_data1;
  logic [IW-1:0] rsp_ir1, ir_in1;
  logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1;

  logic [DW-1:0] model = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Slave model: a DW-bit shift register clocked by tck during SDR
  assign tdo = model[0];
  always @(posedge tck) if (vs_sdr) model = {tdi, model[DW-1:1]};

  nios_cpu_cpu_debug_host_seq #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_skip_dr(cmd_skip_dr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ir(rsp_ir), .busy(busy),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(jtag_state_rti)
  );

  // Second instance with the fastest tck; tdo looped straight back from tdi
  nios_cpu_cpu_debug_host_seq #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_skip_dr(cmd_skip_dr),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_ir(rsp_ir1), .busy(busy1),
    .tck(tck1), .tdi(tdi1), .tdo(tdi1), .ir_in(ir_in1), .ir_out(ir_out),
    .vs_uir(vs_uir1), .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1), .vs_udr(vs_udr1),
    .jtag_state_rti(rti1)
  );

  // Issues one command on dut; lat = negedges from accept edge to rsp_valid (-1 none, -2 never ready)
  task automatic run_cmd(input logic [IW-1:0] ir, input logic [DW-1:0] data, input logic skip,
                         input int abort_at, output int lat, output int cu, output int cc,
                         output int cs, output int cd);
    int w;
    lat = -1; cu = 0; cc = 0; cs = 0; cd = 0; w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      lat = -2;
      return;
    end
    cmd_ir = ir; cmd_data = data; cmd_skip_dr = skip; cmd_valid = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) cmd_valid = 1'b0;
      cu += vs_uir ? 1 : 0;
      cc += vs_cdr ? 1 : 0;
      cs += vs_sdr ? 1 : 0;
      cd += vs_udr ? 1 : 0;
      if (n == abort_at) return;
      if (rsp_valid) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic test_reset;
    bit pulsed;
    pulsed = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) pulsed = 1;
    end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (jtag_state_rti !== 1'b1) begin errors++; $display("FAIL reset_rti got %b want 1", jtag_state_rti); end
    checks++; if (tck !== 1'b0 || tdi !== 1'b0) begin errors++; $display("FAIL reset_tck_tdi got %b%b want 00", tck, tdi); end
    checks++; if ({vs_uir, vs_cdr, vs_sdr, vs_udr} !== 4'b0000) begin errors++; $display("FAIL reset_vs got %b want 0000", {vs_uir, vs_cdr, vs_sdr, vs_udr}); end
    checks++; if (pulsed) begin errors++; $display("FAIL reset_rsp_valid got pulse want none"); end
    checks++; if (rsp_data !== '0 || rsp_ir !== '0 || ir_in !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_regs got data=%h ir=%b ir_in=%b busy=%b want all 0", rsp_data, rsp_ir, ir_in, busy);
    end
  endtask

  task automatic test_full_shift;
    int lat, cu, cc, cs, cd;
    model = 38'h15_1234_5678;
    ir_out = 2'b10;
    run_cmd(2'b01, 38'h2A_5A5A_5A5A, 1'b0, 0, lat, cu, cc, cs, cd);
    checks++; if (lat !== 165) begin errors++; $display("FAIL full_latency got %0d want 165", lat); end
    checks++; if (rsp_data !== 38'h15_1234_5678) begin errors++; $display("FAIL full_rsp_data got %h want 1512345678", rsp_data); end
    checks++; if (rsp_ir !== 2'b10) begin errors++; $display("FAIL full_rsp_ir got %b want 10", rsp_ir); end
    checks++; if (cu !== 4 || cc !== 4 || cd !== 4) begin errors++; $display("FAIL full_strobe_len got uir=%0d cdr=%0d udr=%0d want 4 each", cu, cc, cd); end
    checks++; if (cs !== 152) begin errors++; $display("FAIL full_sdr_len got %0d want 152", cs); end
    checks++; if (model !== 38'h2A_5A5A_5A5A) begin errors++; $display("FAIL full_slave_model got %h want 2a5a5a5a5a", model); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || jtag_state_rti !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL full_back_idle got ready=%b rti=%b rsp=%b want 1 1 0", cmd_ready, jtag_state_rti, rsp_valid);
    end
    checks++; if (rsp_data !== 38'h15_1234_5678 || ir_in !== 2'b01) begin
      errors++; $display("FAIL full_hold got data=%h ir_in=%b want 1512345678 01", rsp_data, ir_in);
    end
  endtask

  task automatic test_skip_dr;
    int lat, cu, cc, cs, cd;
    ir_out = 2'b11;
    run_cmd(2'b10, 38'h3F_0000_FFFF, 1'b1, 0, lat, cu, cc, cs, cd);
    checks++; if (lat !== 5) begin errors++; $display("FAIL skip_latency got %0d want 5", lat); end
    checks++; if (rsp_ir !== 2'b11) begin errors++; $display("FAIL skip_rsp_ir got %b want 11", rsp_ir); end
    checks++; if (cu !== 4) begin errors++; $display("FAIL skip_uir_len got %0d want 4", cu); end
    checks++; if (cc !== 0 || cs !== 0 || cd !== 0) begin errors++; $display("FAIL skip_no_dr got cdr=%0d sdr=%0d udr=%0d want 0", cc, cs, cd); end
    checks++; if (ir_in !== 2'b10) begin errors++; $display("FAIL skip_ir_in got %b want 10", ir_in); end
  endtask

  task automatic test_back_to_back;
    int lat, w;
    bit ready_seen;
    lat = -1; ready_seen = 0; w = 0;
    ir_out = 2'b01;
    cmd_skip_dr = 1'b1; cmd_ir = 2'b10;
    @(negedge clk);
    while (!cmd_ready && w < 400) begin @(negedge clk); w++; end
    cmd_valid = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) cmd_ir = 2'b11;
      if (rsp_valid) begin lat = n; break; end
      if (cmd_ready) ready_seen = 1;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_first_latency got %0d want 5", lat); end
    checks++; if (ready_seen) begin errors++; $display("FAIL b2b_ready_mid got ready=1 want 0 while busy"); end
    checks++; if (ir_in !== 2'b10 || rsp_ir !== 2'b01) begin errors++; $display("FAIL b2b_first_ir got ir_in=%b rsp_ir=%b want 10 01", ir_in, rsp_ir); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap got ready=%b want 1", cmd_ready); end
    @(negedge clk);
    checks++; if (vs_uir !== 1'b1 || ir_in !== 2'b11) begin errors++; $display("FAIL b2b_second_accept got uir=%b ir_in=%b want 1 11", vs_uir, ir_in); end
    cmd_valid = 1'b0;
    lat = -1;
    for (int n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = n; break; end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_second_latency got %0d want 5", lat); end
  endtask

  task automatic test_async_reset;
    int lat, cu, cc, cs, cd;
    bit pulsed;
    pulsed = 0;
    model = 38'h3F_FFFF_FFFF;
    run_cmd(2'b11, 38'h3F_FFFF_FFFF, 1'b0, 51, lat, cu, cc, cs, cd);
    checks++; if (vs_sdr !== 1'b1 || tck !== 1'b1 || tdi !== 1'b1) begin
      errors++; $display("FAIL arst_pre got sdr=%b tck=%b tdi=%b want 1 1 1", vs_sdr, tck, tdi);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || jtag_state_rti !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL arst_ctrl got ready=%b rti=%b busy=%b want 1 1 0", cmd_ready, jtag_state_rti, busy);
    end
    checks++; if (tck !== 1'b0 || tdi !== 1'b0 || ir_in !== '0 || {vs_uir, vs_cdr, vs_sdr, vs_udr} !== 4'b0) begin
      errors++; $display("FAIL arst_jtag got tck=%b tdi=%b ir_in=%b vs=%b want 0", tck, tdi, ir_in, {vs_uir, vs_cdr, vs_sdr, vs_udr});
    end
    checks++; if (rsp_data !== '0 || rsp_ir !== '0) begin errors++; $display("FAIL arst_rsp got data=%h ir=%b want 0", rsp_data, rsp_ir); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) pulsed = 1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) pulsed = 1;
    end
    checks++; if (pulsed) begin errors++; $display("FAIL arst_no_rsp got pulse want none"); end
    model = 38'h0C_3C3C_0F0F;
    run_cmd(2'b11, 38'h11_2233_4455, 1'b0, 0, lat, cu, cc, cs, cd);
    checks++; if (lat !== 165) begin errors++; $display("FAIL arst_after_latency got %0d want 165", lat); end
    checks++; if (rsp_data !== 38'h0C_3C3C_0F0F) begin errors++; $display("FAIL arst_after_data got %h want 0c3c3c0f0f", rsp_data); end
    checks++; if (model !== 38'h11_2233_4455) begin errors++; $display("FAIL arst_after_model got %h want 1122334455", model); end
  endtask

  task automatic test_tck_div1;
    logic prev_tdi, prev_tck;
    int lat, toggles, changes, bad;
    lat = -1; toggles = 0; changes = 0; bad = 0;
    cmd_ir = 2'b01; cmd_data = 38'h25_A5C3_9E71; cmd_skip_dr = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready1 !== 1'b1) begin errors++; $display("FAIL div1_ready got %b want 1", cmd_ready1); end
    cmd_valid1 = 1'b1;
    prev_tdi = tdi1; prev_tck = tck1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) cmd_valid1 = 1'b0;
      if (tck1 !== prev_tck) toggles++;
      if (tdi1 !== prev_tdi) begin
        changes++;
        if (!(prev_tck === 1'b1 && tck1 === 1'b0)) bad++;
      end
      prev_tdi = tdi1; prev_tck = tck1;
      if (rsp_valid1) begin lat = n; break; end
    end
    checks++; if (lat !== 83) begin errors++; $display("FAIL div1_latency got %0d want 83", lat); end
    checks++; if (toggles !== 82) begin errors++; $display("FAIL div1_tck_toggles got %0d want 82", toggles); end
    checks++; if (bad !== 0 || changes == 0) begin errors++; $display("FAIL div1_tdi_on_fall got bad=%0d changes=%0d want 0 and >0", bad, changes); end
    checks++; if (rsp_data1 !== 38'h25_A5C3_9E71) begin errors++; $display("FAIL div1_loopback got %h want 25a5c39e71", rsp_data1); end
  endtask

  initial begin
    test_reset();
    test_full_shift();
    test_skip_dr();
    test_back_to_back();
    test_async_reset();
    test_tck_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
